nn_inference_ctrl: RTL

Sequencer in front of the speech-classification network pipeline (dense/dropout layers feeding the final layer).
- Collects one frame of 12-bit feature words from a streaming valid/ready source into a holding register.
- Holds that vector stable at the network input for the fixed pipeline latency, then samples the 2-bit class.
- Returns the class on a valid/ready result interface and enforces one inference in flight at a time.

---
 rtl/nn_inference_ctrl_if.sv | 37 +++
 rtl/nn_inference_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/nn_inference_ctrl_if.sv
// nn_inference_ctrl_if
//   Handshake bundle between the inference sequencer and its neighbours.
//   Feature stream (valid/ready, with last marker) and result stream (valid/ready).
//
//   master modport: feature producer / result consumer side
//   slave  modport: the sequencer (nn_inference_ctrl)
//
//   Signals:
//     feat_valid  feature word valid
//     feat_data   signed feature word (DATA_W bits)
//     feat_last   last word of a frame
//     feat_ready  sequencer accepts a feature word
//     res_valid   result available
//     res_class   inferred class (CLASS_W bits)
//     res_ready   result consumer ready
interface nn_inference_ctrl_if #(
    parameter int unsigned DATA_W  = 12,
    parameter int unsigned CLASS_W = 2
);
    logic                      feat_valid;
    logic signed [DATA_W-1:0]  feat_data;
    logic                      feat_last;
    logic                      feat_ready;
    logic                      res_valid;
    logic        [CLASS_W-1:0] res_class;
    logic                      res_ready;

    modport master (
        output feat_valid, feat_data, feat_last, res_ready,
        input  feat_ready, res_valid, res_class
    );

    modport slave (
        input  feat_valid, feat_data, feat_last, res_ready,
        output feat_ready, res_valid, res_class
    );
endinterface

// File: rtl/nn_inference_ctrl.sv
// nn_inference_ctrl
//   Sequencer in front of the speech-classification network. Collects one frame of
//   IN_SIZE feature words into a holding register, holds it stable at the network
//   input for NN_LATENCY cycles, samples the network class and offers it on a
//   valid/ready result port. Only one inference is in flight at a time.
//
//   Optional build macro NN_INFERENCE_CNT_EN adds the infer_cnt / err_cnt counters.
//
//   Ports:
//     clk        system clock (rising edge)
//     rst        asynchronous reset, active-low
//     bus        feature + result handshakes (nn_inference_ctrl_if.slave)
//     nn_in_vec  packed vector to the network, word i at [i*DATA_W +: DATA_W]
//     nn_class   class output of the network
//     busy       high in every state except idle
//     err_short  sticky: frame ended before IN_SIZE words
//     err_long   sticky: frame exceeded IN_SIZE words
//     err_clr    synchronous clear of the sticky flags (a same-cycle set wins)
//     infer_cnt  (NN_INFERENCE_CNT_EN) completed result transfers, saturating
//     err_cnt    (NN_INFERENCE_CNT_EN) frames flagged short or long, saturating
module nn_inference_ctrl #(
    parameter int unsigned IN_SIZE    = 16,
    parameter int unsigned DATA_W     = 12,
    parameter int unsigned NN_LATENCY = 8,
    parameter int unsigned CLASS_W    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    nn_inference_ctrl_if.slave        bus,
    output logic [IN_SIZE*DATA_W-1:0] nn_in_vec,
    input  logic [CLASS_W-1:0]        nn_class,
    output logic                      busy,
    output logic                      err_short,
    output logic                      err_long,
    input  logic                      err_clr
`ifdef NN_INFERENCE_CNT_EN
    ,
    output logic [15:0]               infer_cnt,
    output logic [7:0]                err_cnt
`endif
);

    localparam int unsigned IDX_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IN_SIZE - 1);
    localparam logic [7:0] LAT_END = 8'(NN_LATENCY - 1);

    localparam logic [2:0] StIdle   = 3'd0;
    localparam logic [2:0] StLoad   = 3'd1;
    localparam logic [2:0] StDrain  = 3'd2;
    localparam logic [2:0] StRun    = 3'd3;
    localparam logic [2:0] StResult = 3'd4;

    logic [2:0]                state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [7:0]                lat_q, lat_d;
    logic [IN_SIZE*DATA_W-1:0] vec_q, vec_d;
    logic                      res_valid_q, res_valid_d;
    logic [CLASS_W-1:0]        res_class_q, res_class_d;
    logic                      err_short_q, err_short_d;
    logic                      err_long_q, err_long_d;
    logic                      feat_ready_q, feat_ready_d;

    logic feat_acc;
    logic res_acc;
    logic set_short;
    logic set_long;

    assign feat_acc = bus.feat_valid & feat_ready_q;
    assign res_acc  = res_valid_q & bus.res_ready;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lat_d       = lat_q;
        vec_d       = vec_q;
        res_valid_d = res_valid_q;
        res_class_d = res_class_q;
        set_short   = 1'b0;
        set_long    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (feat_acc) begin
                    vec_d[0 +: DATA_W] = bus.feat_data;
                    if (bus.feat_last) begin
                        // Short frame ending at word 0: rest of the vector zero-filled now.
                        for (int i = 1; i < int'(IN_SIZE); i++) begin
                            vec_d[i*DATA_W +: DATA_W] = '0;
                        end
                        set_short = (IN_SIZE > 1);
                        lat_d     = '0;
                        state_d   = StRun;
                    end else if (IN_SIZE == 1) begin
                        // Single-word frames: a missing last marker means the frame is too long.
                        set_long = 1'b1;
                        state_d  = StDrain;
                    end else begin
                        idx_d   = IDX_W'(1);
                        state_d = StLoad;
                    end
                end
            end

            StLoad: begin
                if (feat_acc) begin
                    for (int i = 0; i < int'(IN_SIZE); i++) begin
                        if (i == int'(idx_q)) begin
                            vec_d[i*DATA_W +: DATA_W] = bus.feat_data;
                        end else if (bus.feat_last && i > int'(idx_q)) begin
                            vec_d[i*DATA_W +: DATA_W] = '0;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        if (bus.feat_last) begin
                            lat_d   = '0;
                            state_d = StRun;
                        end else begin
                            set_long = 1'b1;
                            state_d  = StDrain;
                        end
                    end else if (bus.feat_last) begin
                        set_short = 1'b1;
                        lat_d     = '0;
                        state_d   = StRun;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            StDrain: begin
                // Surplus words are swallowed until the frame's last marker.
                if (feat_acc && bus.feat_last) begin
                    lat_d   = '0;
                    state_d = StRun;
                end
            end

            StRun: begin
                if (lat_q == LAT_END) begin
                    res_class_d = nn_class;
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end else begin
                    lat_d = lat_q + 8'd1;
                end
            end

            StResult: begin
                if (res_acc) begin
                    res_valid_d = 1'b0;
                    idx_d       = '0;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        // Ready is a pure register so it has no combinational path from valid/ready inputs.
        feat_ready_d = (state_d == StIdle) || (state_d == StLoad) || (state_d == StDrain);

        err_short_d = set_short ? 1'b1 : (err_clr ? 1'b0 : err_short_q);
        err_long_d  = set_long  ? 1'b1 : (err_clr ? 1'b0 : err_long_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            lat_q        <= '0;
            vec_q        <= '0;
            res_valid_q  <= 1'b0;
            res_class_q  <= '0;
            err_short_q  <= 1'b0;
            err_long_q   <= 1'b0;
            feat_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lat_q        <= lat_d;
            vec_q        <= vec_d;
            res_valid_q  <= res_valid_d;
            res_class_q  <= res_class_d;
            err_short_q  <= err_short_d;
            err_long_q   <= err_long_d;
            feat_ready_q <= feat_ready_d;
        end
    end

    assign bus.feat_ready = feat_ready_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_class  = res_class_q;
    assign nn_in_vec      = vec_q;
    assign busy           = (state_q != StIdle);
    assign err_short      = err_short_q;
    assign err_long       = err_long_q;

`ifdef NN_INFERENCE_CNT_EN
    logic [15:0] infer_cnt_q, infer_cnt_d, infer_base;
    logic [7:0]  err_cnt_q, err_cnt_d, err_base;

    // Clear applies first, so an event in the clearing cycle is still counted.
    always_comb begin
        infer_base  = err_clr ? 16'd0 : infer_cnt_q;
        err_base    = err_clr ? 8'd0 : err_cnt_q;
        infer_cnt_d = infer_base;
        err_cnt_d   = err_base;
        if (res_acc && infer_base != 16'hFFFF) begin
            infer_cnt_d = infer_base + 16'd1;
        end
        if ((set_short || set_long) && err_base != 8'hFF) begin
            err_cnt_d = err_base + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            infer_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            infer_cnt_q <= infer_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign infer_cnt = infer_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule
